runner_ctrl: RTL and testbench

RUNNER_CTRL -- requirements
Module: runner_ctrl

---
 rtl/runner_pkg.sv | 53 +++++
 rtl/runner_physics.sv | 116 +++++++++++
 rtl/runner_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_runner_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/runner_pkg.sv
// Shared types and default physics constants for the runner character.
// Used by runner_ctrl, runner_physics and by the renderer / collision logic.
package runner_pkg;

  localparam int DEF_POS_W           = 12;
  localparam int DEF_GROUND_Y        = 93;
  localparam int DEF_START_X         = 20;
  localparam int DEF_HEIGHT          = 47;
  localparam int DEF_WIDTH           = 44;
  localparam int DEF_WIDTH_DUCK      = 59;
  localparam int DEF_GRAV_NUM        = 6;
  localparam int DEF_GRAV_DEN        = 10;
  localparam int DEF_INIT_JUMP_V     = -10;
  localparam int DEF_DROP_V          = -5;
  localparam int DEF_SPEED_DROP_V    = 1;
  localparam int DEF_SPEED_DROP_COEF = 3;
  localparam int DEF_MIN_RISE        = 30;
  localparam int DEF_MAX_JUMP_Y      = 30;
  localparam int DEF_MAX_AIR_JUMPS   = 1;

  typedef enum logic [2:0] {
    WAITING, RUNNING, JUMPING, DROPPING, DUCKING, CRASHED
  } runner_state_t;

  typedef enum logic [2:0] {
    WAITING0, WAITING1, RUNNING0, RUNNING1, JUMPING0, DUCKING0, DUCKING1, CRASHED0
  } runner_frame_t;

  // Command from the FSM to the vertical integrator for one update tick.
  typedef enum logic [2:0] {
    PH_HOLD,    // no change
    PH_HOME,    // back on the ground: y=GROUND_Y, v=0, acc=0
    PH_LAUNCH,  // start (or restart) a jump
    PH_DROP,    // enter fast drop
    PH_STEP     // one airborne integration step
  } phys_cmd_t;

  // Sprite frame for a given state and animation phase (timer 0..59).
  function automatic runner_frame_t frame_of(runner_state_t s, logic [5:0] timer);
    int unsigned   t;
    runner_frame_t f;
    t = 32'(timer);
    case (s)
      WAITING:           f = (t >= 30) ? WAITING0 : WAITING1;
      RUNNING:           f = ((t % 10) <= 5) ? RUNNING0 : RUNNING1;
      JUMPING, DROPPING: f = JUMPING0;
      DUCKING:           f = ((t % 20) <= 10) ? DUCKING0 : DUCKING1;
      default:           f = CRASHED0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/runner_physics.sv
// Vertical integrator for the runner: fractional gravity accumulator,
// velocity, y position and landing detection.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_cmd         per-tick command from the FSM (HOLD when no update)
//   i_dropping    selects the fast-drop coefficient for the step
//   i_jump/i_duck held controls (drop clamp and reached_min)
//   i_speed       game speed, adds to the launch velocity
//   o_y           top edge of the sprite (signed)
//   o_land        this tick's step would put the runner below ground
module runner_physics
  import runner_pkg::*;
#(
  parameter int POS_W           = DEF_POS_W,
  parameter int GROUND_Y        = DEF_GROUND_Y,
  parameter int GRAV_NUM        = DEF_GRAV_NUM,
  parameter int GRAV_DEN        = DEF_GRAV_DEN,
  parameter int INIT_JUMP_V     = DEF_INIT_JUMP_V,
  parameter int DROP_V          = DEF_DROP_V,
  parameter int SPEED_DROP_V    = DEF_SPEED_DROP_V,
  parameter int SPEED_DROP_COEF = DEF_SPEED_DROP_COEF,
  parameter int MIN_RISE        = DEF_MIN_RISE,
  parameter int MAX_JUMP_Y      = DEF_MAX_JUMP_Y
) (
  input  logic                    clk,
  input  logic                    rst,
  input  phys_cmd_t               i_cmd,
  input  logic                    i_dropping,
  input  logic                    i_jump,
  input  logic                    i_duck,
  input  logic [4:0]              i_speed,
  output logic signed [POS_W-1:0] o_y,
  output logic                    o_land
);

  localparam logic signed [POS_W-1:0] GROUND_S = POS_W'(GROUND_Y);
  localparam logic signed [POS_W-1:0] RISE_S   = POS_W'(GROUND_Y - MIN_RISE);
  localparam logic signed [POS_W-1:0] APEX_S   = POS_W'(MAX_JUMP_Y);
  localparam logic signed [9:0]       INIT_V_S = 10'(INIT_JUMP_V);
  localparam logic signed [9:0]       DROP_V_S = 10'(DROP_V);
  localparam logic signed [9:0]       SDROP_S  = 10'(SPEED_DROP_V);
  localparam logic [7:0]              GN       = 8'(GRAV_NUM);
  localparam logic [7:0]              GD       = 8'(GRAV_DEN);

  logic signed [POS_W-1:0] r_y;
  logic signed [9:0]       r_v;
  logic [7:0]              r_acc;
  logic                    r_min;

  logic signed [POS_W-1:0] w_coef;
  logic                    w_clamp;
  logic signed [9:0]       w_v_eff;
  logic                    w_carry;
  logic signed [9:0]       w_v_step;
  logic signed [POS_W-1:0] w_v_ext;
  logic signed [POS_W-1:0] w_vs_ext;
  logic signed [POS_W-1:0] w_y_test;
  logic signed [POS_W-1:0] w_y_step;
  logic [7:0]              w_acc_step;
  logic signed [9:0]       w_launch_v;
  logic                    w_min_air;

  // The drop clamp is applied before integration, so both the landing test
  // and the step use the clamped velocity.
  always_comb begin
    w_coef     = i_dropping ? POS_W'(SPEED_DROP_COEF) : POS_W'(1);
    w_clamp    = r_min && (!i_jump || (r_y < APEX_S)) && (r_v < DROP_V_S);
    w_v_eff    = w_clamp ? DROP_V_S : r_v;
    w_carry    = (r_acc + GN) >= GD;
    w_v_step   = w_carry ? (w_v_eff + 10'sd1) : w_v_eff;
    w_acc_step = w_carry ? (r_acc + GN - GD) : (r_acc + GN);
    w_v_ext    = POS_W'(w_v_eff);
    w_vs_ext   = POS_W'(w_v_step);
    w_y_test   = r_y + w_v_ext * w_coef;
    w_y_step   = r_y + w_vs_ext * w_coef;
    w_launch_v = INIT_V_S - $signed(10'(i_speed >> 3));
    w_min_air  = r_min | (r_y < RISE_S) | i_duck;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= GROUND_S;
      r_v   <= '0;
      r_acc <= '0;
      r_min <= 1'b0;
    end else begin
      case (i_cmd)
        PH_HOME: begin
          r_y   <= GROUND_S;
          r_v   <= '0;
          r_acc <= '0;
        end
        PH_LAUNCH: begin
          r_v   <= w_launch_v;
          r_acc <= '0;
          r_min <= 1'b0;
        end
        PH_DROP: begin
          r_v   <= SDROP_S;
          r_min <= w_min_air;
        end
        PH_STEP: begin
          r_y   <= w_y_step;
          r_v   <= w_v_step;
          r_acc <= w_acc_step;
          r_min <= w_min_air;
        end
        default: ;
      endcase
    end
  end

  assign o_y    = r_y;
  assign o_land = w_y_test > GROUND_S;

endmodule

// File: rtl/runner_ctrl.sv
// Runner character controller: game-state FSM, horizontal position,
// air-jump budget and sprite frame selection. Vertical motion lives in
// runner_physics.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   update          game tick strobe; state/physics move only on it
//   timer           animation phase 0..59
//   speed           game speed (adds to jump launch velocity)
//   jump/duck       held controls
//   crash/restart   collision flag, leave CRASHED
//   x_pos/y_pos     sprite left/top edge (signed)
//   width/height    sprite bounding box
//   state/frame     current state, registered sprite frame
//   air_jumps_left  remaining extra jumps while airborne
module runner_ctrl
  import runner_pkg::*;
#(
  parameter int POS_W           = DEF_POS_W,
  parameter int GROUND_Y        = DEF_GROUND_Y,
  parameter int START_X         = DEF_START_X,
  parameter int HEIGHT          = DEF_HEIGHT,
  parameter int WIDTH           = DEF_WIDTH,
  parameter int WIDTH_DUCK      = DEF_WIDTH_DUCK,
  parameter int GRAV_NUM        = DEF_GRAV_NUM,
  parameter int GRAV_DEN        = DEF_GRAV_DEN,
  parameter int INIT_JUMP_V     = DEF_INIT_JUMP_V,
  parameter int DROP_V          = DEF_DROP_V,
  parameter int SPEED_DROP_V    = DEF_SPEED_DROP_V,
  parameter int SPEED_DROP_COEF = DEF_SPEED_DROP_COEF,
  parameter int MIN_RISE        = DEF_MIN_RISE,
  parameter int MAX_JUMP_Y      = DEF_MAX_JUMP_Y,
  parameter int MAX_AIR_JUMPS   = DEF_MAX_AIR_JUMPS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    update,
  input  logic [5:0]              timer,
  input  logic [4:0]              speed,
  input  logic                    jump,
  input  logic                    duck,
  input  logic                    crash,
  input  logic                    restart,
  output logic signed [POS_W-1:0] x_pos,
  output logic signed [POS_W-1:0] y_pos,
  output logic [9:0]              width,
  output logic [9:0]              height,
  output runner_state_t           state,
  output runner_frame_t           frame,
  output logic [1:0]              air_jumps_left
);

  localparam logic signed [POS_W-1:0] START_X_S = POS_W'(START_X);
  localparam logic [1:0]              AJ_MAX    = 2'(MAX_AIR_JUMPS);

  runner_state_t           r_state;
  runner_frame_t           r_frame;
  logic signed [POS_W-1:0] r_x;
  logic                    r_jump_prev;
  logic [1:0]              r_aj;

  runner_state_t           w_state_nxt;
  runner_frame_t           w_frame_nxt;
  phys_cmd_t               w_cmd;
  logic signed [POS_W-1:0] w_x_nxt;
  logic [1:0]              w_aj_nxt;
  logic                    w_land;
  logic                    w_air_edge;
  logic                    w_dropping;

  assign w_air_edge = jump & ~r_jump_prev;
  assign w_dropping = (r_state == DROPPING);

  runner_physics #(
    .POS_W           (POS_W),
    .GROUND_Y        (GROUND_Y),
    .GRAV_NUM        (GRAV_NUM),
    .GRAV_DEN        (GRAV_DEN),
    .INIT_JUMP_V     (INIT_JUMP_V),
    .DROP_V          (DROP_V),
    .SPEED_DROP_V    (SPEED_DROP_V),
    .SPEED_DROP_COEF (SPEED_DROP_COEF),
    .MIN_RISE        (MIN_RISE),
    .MAX_JUMP_Y      (MAX_JUMP_Y)
  ) u_phys (
    .clk        (clk),
    .rst        (rst),
    .i_cmd      (w_cmd),
    .i_dropping (w_dropping),
    .i_jump     (jump),
    .i_duck     (duck),
    .i_speed    (speed),
    .o_y        (y_pos),
    .o_land     (w_land)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)         r_state <= WAITING;
    else if (update) r_state <= w_state_nxt;
  end

  // Next state and per-tick commands
  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = PH_HOLD;
    w_x_nxt     = r_x;
    w_aj_nxt    = r_aj;
    if (update) begin
      if (r_state == CRASHED && restart) begin
        w_state_nxt = WAITING;
        w_cmd       = PH_HOME;
        w_x_nxt     = START_X_S;
      end else if (crash) begin
        w_state_nxt = CRASHED;
        if (r_state == DUCKING) w_x_nxt = r_x + POS_W'(1);
      end else begin
        case (r_state)
          WAITING: if (jump) w_state_nxt = RUNNING;
          RUNNING: begin
            if (jump) begin
              w_state_nxt = JUMPING;
              w_cmd       = PH_LAUNCH;
              w_aj_nxt    = AJ_MAX;
            end else if (duck) begin
              w_state_nxt = DUCKING;
            end
          end
          DUCKING: if (!duck) w_state_nxt = RUNNING;
          JUMPING, DROPPING: begin
            // Landing wins over an air jump on the same tick.
            if (w_land) begin
              w_state_nxt = RUNNING;
              w_cmd       = PH_HOME;
              w_x_nxt     = START_X_S;
            end else if (w_air_edge && r_aj != 2'd0) begin
              w_state_nxt = JUMPING;
              w_cmd       = PH_LAUNCH;
              w_aj_nxt    = r_aj - 2'd1;
            end else if (r_state == JUMPING && duck) begin
              w_state_nxt = DROPPING;
              w_cmd       = PH_DROP;
            end else begin
              w_state_nxt = duck ? DROPPING : JUMPING;
              w_cmd       = PH_STEP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs: frame follows the state being entered, every cycle
  always_comb begin
    w_frame_nxt = frame_of(update ? w_state_nxt : r_state, timer);
    width       = (r_state == DUCKING) ? 10'(WIDTH_DUCK) : 10'(WIDTH);
    height      = 10'(HEIGHT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame     <= WAITING0;
      r_x         <= START_X_S;
      r_jump_prev <= 1'b0;
      r_aj        <= AJ_MAX;
    end else begin
      r_frame <= w_frame_nxt;
      if (update) begin
        r_x         <= w_x_nxt;
        r_jump_prev <= jump;
        r_aj        <= w_aj_nxt;
      end
    end
  end

  assign state          = r_state;
  assign frame          = r_frame;
  assign x_pos          = r_x;
  assign air_jumps_left = r_aj;

endmodule

// File: tb/tb_runner_ctrl.sv
module tb_runner_ctrl;
  import runner_pkg::*;

  logic clk = 1'b0;
  logic rst, update, jump, duck, crash, restart;
  logic [5:0] timer;
  logic [4:0] speed;
  logic signed [11:0] x_pos, y_pos;
  logic [9:0] width, height;
  runner_state_t state;
  runner_frame_t frame;
  logic [1:0] air_jumps_left;

  int checks = 0;
  int errors = 0;

  // reference model
  int m_x, m_y, m_v, m_acc, m_min, m_jp, m_aj;
  runner_state_t m_state;
  runner_frame_t m_frame;

  runner_ctrl dut (
    .clk(clk), .rst(rst), .update(update), .timer(timer), .speed(speed),
    .jump(jump), .duck(duck), .crash(crash), .restart(restart),
    .x_pos(x_pos), .y_pos(y_pos), .width(width), .height(height),
    .state(state), .frame(frame), .air_jumps_left(air_jumps_left)
  );

  always #5 clk = ~clk;

  function automatic runner_frame_t fref(runner_state_t s, int t);
    case (s)
      WAITING:           return (t >= 30) ? WAITING0 : WAITING1;
      RUNNING:           return (t % 10 <= 5) ? RUNNING0 : RUNNING1;
      JUMPING, DROPPING: return JUMPING0;
      DUCKING:           return (t % 20 <= 10) ? DUCKING0 : DUCKING1;
      default:           return CRASHED0;
    endcase
  endfunction

  task automatic launch();
    m_v   = -10 - (int'(speed) / 8);
    m_acc = 0;
    m_min = 0;
  endtask

  task automatic model_step();
    runner_state_t nst;
    int coef, v;
    if (rst) begin
      m_state = WAITING; m_x = 20; m_y = 93; m_v = 0; m_acc = 0;
      m_min = 0; m_jp = 0; m_aj = 1; m_frame = WAITING0;
      return;
    end
    nst = m_state;
    if (update) begin
      if (m_state == CRASHED && restart) begin
        nst = WAITING; m_x = 20; m_y = 93; m_v = 0; m_acc = 0;
      end else if (crash) begin
        nst = CRASHED;
        if (m_state == DUCKING) m_x = m_x + 1;
      end else begin
        case (m_state)
          WAITING: if (jump) nst = RUNNING;
          RUNNING: begin
            if (jump) begin nst = JUMPING; launch(); m_aj = 1; end
            else if (duck) nst = DUCKING;
          end
          DUCKING: if (!duck) nst = RUNNING;
          JUMPING, DROPPING: begin
            coef = (m_state == DROPPING) ? 3 : 1;
            v = m_v;
            if (m_min != 0 && (!jump || m_y < 30) && v < -5) v = -5;
            if (m_y + v * coef > 93) begin
              nst = RUNNING; m_y = 93; m_v = 0; m_acc = 0; m_x = 20;
            end else if (jump && m_jp == 0 && m_aj > 0) begin
              nst = JUMPING; launch(); m_aj = m_aj - 1;
            end else begin
              if (m_y < 63 || duck) m_min = 1;
              if (m_state == JUMPING && duck) begin
                nst = DROPPING; m_v = 1;
              end else begin
                m_acc = m_acc + 6;
                if (m_acc >= 10) begin m_acc = m_acc - 10; v = v + 1; end
                m_y = m_y + v * coef;
                m_v = v;
                nst = duck ? DROPPING : JUMPING;
              end
            end
          end
          default: ;
        endcase
      end
      m_jp = jump ? 1 : 0;
      m_state = nst;
    end
    m_frame = fref(m_state, int'(timer));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic u, logic j, logic d);
    update = u; jump = j; duck = d; crash = 1'b0; restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_in(1'b1, 1'b1, 1'b0); timer = 6'd10; speed = '0;
    cycle(); cycle();
    checks++; if (frame !== WAITING0) begin errors++; $display("FAIL reset_frame: got %0d want %0d", frame, WAITING0); end
    rst = 1'b0; set_in(1'b0, 1'b0, 1'b0); timer = 6'd45;
    cycle();
    checks++; if (state !== WAITING) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, WAITING); end
    checks++; if (x_pos !== 12'sd20) begin errors++; $display("FAIL reset_x: got %0d want 20", x_pos); end
    checks++; if (y_pos !== 12'sd93) begin errors++; $display("FAIL reset_y: got %0d want 93", y_pos); end
    checks++; if (frame !== WAITING0) begin errors++; $display("FAIL reset_frame45: got %0d want %0d", frame, WAITING0); end
    checks++; if (air_jumps_left !== 2'd1) begin errors++; $display("FAIL reset_aj: got %0d want 1", air_jumps_left); end
    checks++; if (height !== 10'd47) begin errors++; $display("FAIL height: got %0d want 47", height); end
    set_in(1'b1, 1'b1, 1'b0);
    cycle();
    checks++; if (state !== RUNNING) begin errors++; $display("FAIL wait_to_run: got %0d want %0d", state, RUNNING); end
  endtask

  task automatic test_jump();
    speed = 5'd16; set_in(1'b1, 1'b1, 1'b0);
    cycle();
    checks++; if (state !== JUMPING) begin errors++; $display("FAIL jump_state: got %0d want %0d", state, JUMPING); end
    checks++; if (dut.u_phys.r_v !== -10'sd12) begin errors++; $display("FAIL jump_v0: got %0d want -12", dut.u_phys.r_v); end
    checks++; if (y_pos !== 12'sd93) begin errors++; $display("FAIL jump_y0: got %0d want 93", y_pos); end
    cycle();
    checks++; if (y_pos !== 12'sd81) begin errors++; $display("FAIL jump_y1: got %0d want 81", y_pos); end
    checks++; if (dut.u_phys.r_acc !== 8'd6) begin errors++; $display("FAIL jump_acc1: got %0d want 6", dut.u_phys.r_acc); end
    cycle();
    checks++; if (y_pos !== 12'sd70) begin errors++; $display("FAIL jump_y2: got %0d want 70", y_pos); end
    checks++; if (dut.u_phys.r_v !== -10'sd11) begin errors++; $display("FAIL jump_v2: got %0d want -11", dut.u_phys.r_v); end
    checks++; if (dut.u_phys.r_acc !== 8'd2) begin errors++; $display("FAIL jump_acc2: got %0d want 2", dut.u_phys.r_acc); end
  endtask

  task automatic test_drop();
    int k;
    set_in(1'b1, 1'b1, 1'b1);
    cycle();
    checks++; if (state !== DROPPING) begin errors++; $display("FAIL drop_state: got %0d want %0d", state, DROPPING); end
    checks++; if (dut.u_phys.r_v !== 10'sd1) begin errors++; $display("FAIL drop_v: got %0d want 1", dut.u_phys.r_v); end
    checks++; if (y_pos !== 12'sd70) begin errors++; $display("FAIL drop_y_hold: got %0d want 70", y_pos); end
    for (k = 0; k < 40 && state !== RUNNING; k++) begin
      cycle();
      checks++; if (y_pos !== 12'(m_y)) begin errors++; $display("FAIL drop_y_step: got %0d want %0d", y_pos, m_y); end
    end
    checks++; if (state !== RUNNING) begin errors++; $display("FAIL drop_land_timeout: got %0d want %0d", state, RUNNING); end
    checks++; if (y_pos !== 12'sd93) begin errors++; $display("FAIL drop_land_y: got %0d want 93", y_pos); end
  endtask

  task automatic test_air_jump();
    int k;
    speed = '0;
    set_in(1'b1, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 1'b0); cycle();
    checks++; if (dut.u_phys.r_v !== -10'sd10) begin errors++; $display("FAIL air_launch_v: got %0d want -10", dut.u_phys.r_v); end
    set_in(1'b1, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 1'b0); cycle();
    checks++; if (dut.u_phys.r_v !== -10'sd10) begin errors++; $display("FAIL air_jump_v: got %0d want -10", dut.u_phys.r_v); end
    checks++; if (air_jumps_left !== 2'd0) begin errors++; $display("FAIL air_jump_left: got %0d want 0", air_jumps_left); end
    checks++; if (y_pos !== 12'sd83) begin errors++; $display("FAIL air_jump_y: got %0d want 83", y_pos); end
    set_in(1'b1, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 1'b0); cycle();
    checks++; if (dut.u_phys.r_v !== -10'sd9) begin errors++; $display("FAIL air_jump_ignored_v: got %0d want -9", dut.u_phys.r_v); end
    checks++; if (y_pos !== 12'sd64) begin errors++; $display("FAIL air_jump_ignored_y: got %0d want 64", y_pos); end
    checks++; if (state !== JUMPING) begin errors++; $display("FAIL air_jump_state: got %0d want %0d", state, JUMPING); end
    set_in(1'b1, 1'b0, 1'b0);
    for (k = 0; k < 200 && state !== RUNNING; k++) cycle();
    checks++; if (state !== RUNNING) begin errors++; $display("FAIL air_land_timeout: got %0d want %0d", state, RUNNING); end
  endtask

  task automatic test_crash();
    set_in(1'b1, 1'b0, 1'b1); timer = 6'd15; cycle();
    checks++; if (state !== DUCKING) begin errors++; $display("FAIL duck_state: got %0d want %0d", state, DUCKING); end
    checks++; if (width !== 10'd59) begin errors++; $display("FAIL duck_width: got %0d want 59", width); end
    checks++; if (frame !== DUCKING1) begin errors++; $display("FAIL duck_frame: got %0d want %0d", frame, DUCKING1); end
    crash = 1'b1; cycle();
    checks++; if (state !== CRASHED) begin errors++; $display("FAIL crash_state: got %0d want %0d", state, CRASHED); end
    checks++; if (x_pos !== 12'sd21) begin errors++; $display("FAIL crash_x: got %0d want 21", x_pos); end
    checks++; if (frame !== CRASHED0) begin errors++; $display("FAIL crash_frame: got %0d want %0d", frame, CRASHED0); end
    checks++; if (width !== 10'd44) begin errors++; $display("FAIL crash_width: got %0d want 44", width); end
    set_in(1'b1, 1'b1, 1'b0); cycle();
    checks++; if (state !== CRASHED) begin errors++; $display("FAIL crash_hold: got %0d want %0d", state, CRASHED); end
    restart = 1'b1; crash = 1'b1; cycle();
    checks++; if (state !== WAITING) begin errors++; $display("FAIL restart_state: got %0d want %0d", state, WAITING); end
    checks++; if (x_pos !== 12'sd20) begin errors++; $display("FAIL restart_x: got %0d want 20", x_pos); end
    checks++; if (y_pos !== 12'sd93) begin errors++; $display("FAIL restart_y: got %0d want 93", y_pos); end
  endtask

  task automatic test_hold();
    runner_state_t s0;
    logic signed [11:0] x0, y0;
    logic signed [9:0] v0;
    set_in(1'b1, 1'b1, 1'b0); speed = 5'd8; cycle(); cycle(); cycle();
    s0 = state; x0 = x_pos; y0 = y_pos; v0 = dut.u_phys.r_v;
    for (int i = 0; i < 100; i++) begin
      update = 1'b0; jump = 1'($urandom); duck = 1'($urandom);
      crash = 1'($urandom); restart = 1'($urandom); timer = 6'($urandom_range(0, 59));
      cycle();
      checks++; if (state !== s0) begin errors++; $display("FAIL hold_state: got %0d want %0d", state, s0); end
      checks++; if (x_pos !== x0) begin errors++; $display("FAIL hold_x: got %0d want %0d", x_pos, x0); end
      checks++; if (y_pos !== y0) begin errors++; $display("FAIL hold_y: got %0d want %0d", y_pos, y0); end
      checks++; if (dut.u_phys.r_v !== v0) begin errors++; $display("FAIL hold_v: got %0d want %0d", dut.u_phys.r_v, v0); end
      checks++; if (frame !== m_frame) begin errors++; $display("FAIL hold_frame: got %0d want %0d", frame, m_frame); end
    end
  endtask

  task automatic test_reset_mid_jump();
    set_in(1'b1, 1'b1, 1'b0);
    if (state !== JUMPING && state !== DROPPING) begin
      checks++; errors++; $display("FAIL midjump_setup: got %0d want %0d", state, JUMPING);
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++; if (state !== WAITING) begin errors++; $display("FAIL midjump_state: got %0d want %0d", state, WAITING); end
    checks++; if (y_pos !== 12'sd93) begin errors++; $display("FAIL midjump_y: got %0d want 93", y_pos); end
    checks++; if (dut.u_phys.r_v !== 10'sd0) begin errors++; $display("FAIL midjump_v: got %0d want 0", dut.u_phys.r_v); end
    checks++; if (frame !== WAITING0) begin errors++; $display("FAIL midjump_frame: got %0d want %0d", frame, WAITING0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      update  = 1'($urandom_range(0, 1));
      jump    = ($urandom_range(0, 9) < 4);
      duck    = ($urandom_range(0, 9) < 3);
      crash   = ($urandom_range(0, 99) < 3);
      restart = ($urandom_range(0, 9) < 3);
      speed   = 5'($urandom);
      timer   = 6'($urandom_range(0, 59));
      cycle();
      checks++; if (state !== m_state) begin errors++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state, m_state); end
      checks++; if (x_pos !== 12'(m_x)) begin errors++; $display("FAIL rnd_x @%0d: got %0d want %0d", i, x_pos, m_x); end
      checks++; if (y_pos !== 12'(m_y)) begin errors++; $display("FAIL rnd_y @%0d: got %0d want %0d", i, y_pos, m_y); end
      checks++; if (dut.u_phys.r_v !== 10'(m_v)) begin errors++; $display("FAIL rnd_v @%0d: got %0d want %0d", i, dut.u_phys.r_v, m_v); end
      checks++; if (dut.u_phys.r_acc !== 8'(m_acc)) begin errors++; $display("FAIL rnd_acc @%0d: got %0d want %0d", i, dut.u_phys.r_acc, m_acc); end
      checks++; if (air_jumps_left !== 2'(m_aj)) begin errors++; $display("FAIL rnd_aj @%0d: got %0d want %0d", i, air_jumps_left, m_aj); end
      checks++; if (frame !== m_frame) begin errors++; $display("FAIL rnd_frame @%0d: got %0d want %0d", i, frame, m_frame); end
      checks++; if (width !== ((m_state == DUCKING) ? 10'd59 : 10'd44)) begin errors++; $display("FAIL rnd_width @%0d: got %0d state %0d", i, width, m_state); end
    end
  endtask

  initial begin
    rst = 1'b1; update = 1'b0; jump = 1'b0; duck = 1'b0; crash = 1'b0; restart = 1'b0;
    timer = '0; speed = '0;
    test_reset();
    test_jump();
    test_drop();
    test_air_jump();
    test_crash();
    test_hold();
    test_reset_mid_jump();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
